// File: rtl/cnt_run_arb_if.sv
// rtl/cnt_run_arb_if.sv - requester and counter-side signals of cnt_run_arb; pause exists only with CNT_RUN_ARB_PAUSE_EN
interface cnt_run_arb_if #(
  parameter int WIDTH = 4
);
  logic [1:0]       req;
  logic [WIDTH-1:0] len0;
  logic [WIDTH-1:0] len1;
  logic [WIDTH-1:0] cnt_val;
  logic             cnt_en;
  logic             cnt_clr;
  logic [1:0]       gnt;
  logic [1:0]       done;
  logic             busy;
`ifdef CNT_RUN_ARB_PAUSE_EN
  logic             pause;

  modport master (output req, len0, len1, cnt_val, pause,
                  input  cnt_en, cnt_clr, gnt, done, busy);
  modport slave  (input  req, len0, len1, cnt_val, pause,
                  output cnt_en, cnt_clr, gnt, done, busy);
`else
  modport master (output req, len0, len1, cnt_val,
                  input  cnt_en, cnt_clr, gnt, done, busy);
  modport slave  (input  req, len0, len1, cnt_val,
                  output cnt_en, cnt_clr, gnt, done, busy);
`endif
endinterface

// File: rtl/cnt_run_arb.sv
// rtl/cnt_run_arb.sv - two-requester round-robin owner of a shared up-counter
// Optional run pause input enabled by CNT_RUN_ARB_PAUSE_EN.
module cnt_run_arb #(
  parameter int WIDTH = 4
) (
  input logic          clk,
  input logic          clr,
  cnt_run_arb_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_CLR, S_RUN, S_DONE} state_t;

  state_t           state, state_nx;
  logic             win, win_nx, last;
  logic [WIDTH-1:0] tgt;
  logic [1:0]       gnt_r;
  logic             req_win, at_tgt, hold;
  logic             cnt_en_c, cnt_clr_c;

  assign req_win = bus.req[win];
  assign at_tgt  = (bus.cnt_val == tgt);
`ifdef CNT_RUN_ARB_PAUSE_EN
  assign hold = bus.pause;
`else
  assign hold = 1'b0;
`endif

  always_comb begin
    state_nx  = state;
    win_nx    = win;
    cnt_en_c  = 1'b0;
    cnt_clr_c = 1'b0;
    case (state)
      S_IDLE: begin
        if (|bus.req) begin
          state_nx = S_CLR;
          win_nx   = (&bus.req) ? ~last : bus.req[1];
        end
      end
      S_CLR: begin
        cnt_clr_c = 1'b1;
        state_nx  = req_win ? S_RUN : S_IDLE;
      end
      S_RUN: begin
        // abort wins over completion so a dropped request never sees done
        if (!req_win)    state_nx = S_IDLE;
        else if (at_tgt) state_nx = S_DONE;
        else             cnt_en_c = ~hold;
      end
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= S_IDLE;
      win   <= 1'b0;
      last  <= 1'b1;
      tgt   <= '0;
      gnt_r <= 2'b00;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && state_nx == S_CLR) begin
        win   <= win_nx;
        last  <= win_nx;
        tgt   <= win_nx ? bus.len1 : bus.len0;
        gnt_r <= win_nx ? 2'b10 : 2'b01;
      end else if (state_nx == S_IDLE) begin
        gnt_r <= 2'b00;
      end
    end
  end

  assign bus.gnt     = gnt_r;
  assign bus.done    = (state == S_DONE) ? gnt_r : 2'b00;
  assign bus.busy    = (state != S_IDLE);
  assign bus.cnt_en  = cnt_en_c;
  assign bus.cnt_clr = cnt_clr_c;
endmodule

// File: doc/cnt_run_arb.md
Name: cnt_run_arb

Overview:
- Two-requester round-robin controller for one shared WIDTH-bit up-counter (synchronous clear, count enable, count output).
- Grants the counter to one requester at a time and clears it.
- Enables counting until the requester's latched target length is reached, then pulses a per-requester done.
- Sits between requesting control logic and the counter instance; it is the only driver of the counter's en/clear inputs.

Parameters:
WIDTH, 4, counter width; target lengths and cnt_val are WIDTH bits

Ports:
clk  input  1  system clock, all state on rising edge
clr  input  1  asynchronous active-high reset
req  input  2  request per requester; must stay high until done, dropping it aborts
len0  input  WIDTH  target count for requester 0, sampled at grant
len1  input  WIDTH  target count for requester 1, sampled at grant
cnt_val  input  WIDTH  current value of the controlled counter
cnt_en  output  1  counter enable (increment this cycle)
cnt_clr  output  1  counter synchronous clear
gnt  output  2  one-hot grant, registered
done  output  2  one-cycle completion pulse per requester
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (clr high, asynchronous):
  - state=IDLE, gnt=0, done=0, tgt=0, win=0.
  - last=1, so requester 0 wins the first tie.
  - cnt_en=0, cnt_clr=0, busy=0.
- States: IDLE, CLR, RUN, DONE. Single registered state machine; cnt_en, cnt_clr and busy decode from state.
- IDLE:
  - If any req bit is high at edge k: win = the requesting bit. If both are high, win = !last.
  - Latch tgt = len[win], set gnt[win]=1, last=win, go to CLR. The grant is visible in cycle k+1.
- CLR:
  - cnt_clr=1 for exactly one cycle, cnt_en=0, then go to RUN.
  - The counter reads 0 from cycle k+2.
- RUN:
  - cnt_en = req[win] & (cnt_val != tgt).
  - When cnt_val == tgt, go to DONE. cnt_en is already 0 in that cycle, so the counter holds at tgt.
- DONE:
  - done[win]=1 for one cycle; gnt stays high.
  - Next edge: gnt=0, go to IDLE. req is ignored while in DONE.
- Latency:
  - req at edge k gives done in cycle k+3+tgt.
  - tgt=0 goes CLR → RUN → DONE immediately: done in cycle k+3 with no enable cycles.
  - Exactly tgt cycles have cnt_en=1.
- Abort: if req[win] is low while in CLR or RUN:
  - cnt_en is forced 0 that cycle.
  - Next edge: IDLE, gnt=0, no done pulse. last keeps the aborted winner.
- Back-to-back: requester holding req through done re-arbitrates from IDLE. There is one IDLE cycle between done and the new grant. Round-robin favours the other requester if both are pending.
- Max target is 2^WIDTH−1. The counter never wraps under control; the controller never enables it at tgt.
- len changes after grant have no effect until the next grant.
- Reset mid-operation: everything returns to reset values immediately, with no done pulse. The counter is not cleared until the next CLR.
- gnt and done are never both set for different requesters. At most one gnt bit is high.

Optional Feature:
- Macro CNT_RUN_ARB_PAUSE_EN.
- Defined:
  - Adds input pause (1 bit).
  - In RUN, cnt_en = req[win] & !pause & (cnt_val != tgt).
  - The state holds in RUN while paused; the DONE transition still occurs if cnt_val == tgt.
  - pause has no effect in other states.
  - Latency becomes k+3+tgt+(number of paused RUN cycles with cnt_val != tgt).
- Undefined: no pause port; behaviour as above.

Test Plan:
1. Reset, then req=01, len0=5:
   - gnt=01 at k+1; cnt_clr=1 at k+1.
   - cnt_en high 5 cycles; cnt_val reaches 5.
   - done=01 at k+8; gnt=00 at k+9.
2. req=11 from reset, len0=3, len1=2, both held:
   - Requester 0 served first (done at k+6).
   - Requester 1 granted next, done 2+3 cycles after its grant edge.
   - Requester 0 is served again only after 1.
3. len1=0, req=10:
   - cnt_clr pulse; no cnt_en cycles.
   - done=10 at k+3; cnt_val=0.
4. req=01, len0=9; drop req after 4 cnt_en cycles:
   - cnt_en=0 the same cycle; counter holds 4.
   - gnt=00 next cycle; no done.
   - Next req=11 grants requester 1 (last=0).
5. len0=15 (WIDTH=4): exactly 15 enable cycles, cnt_val stops at 15, never wraps to 0, done asserted.
6. Assert clr during RUN at cnt_val=2:
   - gnt, done, busy and cnt_en drop asynchronously.
   - After release with req=01, len0=1, normal sequence completes with done at k+4.
   - With CNT_RUN_ARB_PAUSE_EN, pause held 3 RUN cycles delays done by 3.
